// File: rtl/row_scalar_divider_if.sv
// Start/done handshake bundle for the row-by-scalar divider.
// The controller side drives the request; the divider side returns status.
interface row_scalar_divider_if #(
    parameter int ELEM_W = 8,
    parameter int N_ELEM = 5
);
    localparam int ROW_W = N_ELEM * ELEM_W;

    logic              start;
    logic [ROW_W-1:0]  m_in;
    logic [ELEM_W-1:0] n;
    logic              busy;
    logic              done;
    logic [ROW_W-1:0]  m_out;
    logic              ovf;
    logic              dbz;

    modport master (
        output start, m_in, n,
        input  busy, done, m_out, ovf, dbz
    );

    modport slave (
        input  start, m_in, n,
        output busy, done, m_out, ovf, dbz
    );
endinterface

// File: rtl/row_scalar_divider.sv
// Divides a packed row of signed elements by a signed scalar,
// one element at a time through a shared restoring divider.
module row_scalar_divider #(
    parameter int ELEM_W = 8,
    parameter int N_ELEM = 5
) (
    input logic                clk,
    input logic                rst,
    row_scalar_divider_if.slave bus
);
    localparam int ROW_W = N_ELEM * ELEM_W;
    localparam int IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam int CNT_W = $clog2(ELEM_W);

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        FIX,
        DONE
    } state_t;

    state_t            state;
    logic [ROW_W-1:0]  m_reg;
    logic [ELEM_W-1:0] n_reg;
    logic [ROW_W-1:0]  res;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  cnt;
    logic [ELEM_W-1:0] rem;
    logic [ELEM_W-1:0] quo;
    logic              busy;
    logic              done;
    logic [ROW_W-1:0]  m_out;
    logic              ovf;
    logic              dbz;

    logic [ELEM_W-1:0] elem;
    logic [ELEM_W-1:0] elem_mag;
    logic [ELEM_W-1:0] div_mag;
    logic [ELEM_W:0]   trial;
    logic              fits;
    logic [ELEM_W-1:0] rem_new;
    logic              q_neg;
    logic              is_ovf;
    logic [ELEM_W-1:0] slot_val;
    logic [ROW_W-1:0]  res_next;
    logic              last;

    assign bus.busy  = busy;
    assign bus.done  = done;
    assign bus.m_out = m_out;
    assign bus.ovf   = ovf;
    assign bus.dbz   = dbz;

    // Select the element currently being divided (element 0 sits in the top byte).
    always_comb begin
        elem = '0;
        for (int i = 0; i < N_ELEM; i++) begin
            if (idx == IDX_W'(i)) begin
                elem = m_reg[(N_ELEM-1-i)*ELEM_W +: ELEM_W];
            end
        end
    end

    // One restoring-division step on magnitudes; -128 maps to unsigned 128.
    always_comb begin
        elem_mag = elem[ELEM_W-1] ? (~elem + 1'b1) : elem;
        div_mag  = n_reg[ELEM_W-1] ? (~n_reg + 1'b1) : n_reg;
        trial    = {rem, elem_mag[cnt]};
        fits     = (trial >= {1'b0, div_mag});
        rem_new  = fits ? ELEM_W'(trial - {1'b0, div_mag})
                        : trial[ELEM_W-1:0];
    end

    // Sign-correct the finished quotient and merge it into the result row.
    always_comb begin
        q_neg    = elem[ELEM_W-1] ^ n_reg[ELEM_W-1];
        is_ovf   = (elem == {1'b1, {(ELEM_W-1){1'b0}}}) && (n_reg == '1);
        slot_val = q_neg ? (~quo + 1'b1) : quo;
        if (is_ovf) begin
            slot_val = {1'b1, {(ELEM_W-1){1'b0}}};
        end
        res_next = res;
        for (int i = 0; i < N_ELEM; i++) begin
            if (idx == IDX_W'(i)) begin
                res_next[(N_ELEM-1-i)*ELEM_W +: ELEM_W] = slot_val;
            end
        end
        last = (idx == IDX_W'(N_ELEM - 1));
    end

    // Control FSM with all datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            m_reg <= '0;
            n_reg <= '0;
            res   <= '0;
            idx   <= '0;
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            m_out <= '0;
            ovf   <= 1'b0;
            dbz   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (bus.start) begin
                        m_reg <= bus.m_in;
                        n_reg <= bus.n;
                        res   <= '0;
                        idx   <= '0;
                        cnt   <= CNT_W'(ELEM_W - 1);
                        rem   <= '0;
                        quo   <= '0;
                        ovf   <= 1'b0;
                        busy  <= 1'b1;
                        if (bus.n == '0) begin
                            dbz   <= 1'b1;
                            state <= DONE;
                        end else begin
                            dbz   <= 1'b0;
                            state <= DIV;
                        end
                    end
                end
                DIV: begin
                    rem <= rem_new;
                    quo <= {quo[ELEM_W-2:0], fits};
                    if (cnt == '0) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                FIX: begin
                    res <= res_next;
                    if (is_ovf) begin
                        ovf <= 1'b1;
                    end
                    if (last) begin
                        m_out <= res_next;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        cnt   <= CNT_W'(ELEM_W - 1);
                        rem   <= '0;
                        quo   <= '0;
                        state <= DIV;
                    end
                end
                DONE: begin
                    // The zero-divisor path arrives here without done raised yet.
                    if (!done) begin
                        m_out <= '0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end else begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
